// File: rtl/ram_simple_dual_port_if.sv
// Bus bundle for ram_simple_dual_port: sweep control, write port and read port.
// The RAM uses the slave modport; the agent driving it uses master.
interface ram_simple_dual_port_if #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned BYTE_WIDTH    = 8
);
  localparam int unsigned LANES = DATA_WIDTH / BYTE_WIDTH;

  logic                     clear;
  logic                     busy;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [LANES-1:0]         wr_be;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     rd_en;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_valid;

  modport master (
    output clear, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clear, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output busy, rd_data, rd_valid
  );
endinterface

// File: rtl/ram_simple_dual_port.sv
// Simple-dual-port RAM with byte-lane writes, 1/2-cycle reads, selectable
// read-during-write ordering and a whole-array clear sweep.
module ram_simple_dual_port #(
  parameter int unsigned          ADDRESS_WIDTH  = 4,
  parameter int unsigned          DATA_WIDTH     = 8,
  parameter int unsigned          BYTE_WIDTH     = 8,
  parameter int unsigned          READ_LATENCY   = 1,
  parameter int unsigned          WRITE_FIRST    = 0,
  parameter int unsigned          CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  ram_simple_dual_port_if.slave  bus
);

  localparam int unsigned AW    = ADDRESS_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned BW    = BYTE_WIDTH;
  localparam int unsigned LANES = DW / BW;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            r_busy;
  logic            w_busy_nxt;

  logic            w_mem_we;
  logic [AW-1:0]   w_mem_addr;
  logic [LANES-1:0] w_mem_be;
  logic [DW-1:0]   w_mem_wdata;
  logic            w_rd_acc;
  logic [DW-1:0]   w_rd_word;

  logic [DW-1:0]   r_mem [DEPTH];

  logic            r_rd_valid1;
  logic [DW-1:0]   r_rd_data1;

  // State, sweep counter and busy flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= (CLEAR_ON_RESET != 0);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next state and memory-port steering; the sweep owns the write port
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.wr_addr;
    w_mem_be    = bus.wr_be;
    w_mem_wdata = bus.wr_data;
    w_rd_acc    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we    = i_rst_n;
        w_mem_addr  = r_cnt;
        w_mem_be    = '1;
        w_mem_wdata = CLEAR_VALUE;
        w_cnt_nxt   = r_cnt + AW'(1);
        if (&r_cnt) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        if (bus.clear) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end else begin
          w_mem_we = bus.wr_en & i_rst_n;
          w_rd_acc = bus.rd_en;
        end
      end
    endcase
  end

  // Read word, optionally overlaid with same-address write lanes
  always_comb begin
    w_rd_word = r_mem[bus.rd_addr];
    if ((WRITE_FIRST != 0) && w_mem_we && (w_mem_addr == bus.rd_addr)) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (w_mem_be[k]) begin
          w_rd_word[k*BW +: BW] = w_mem_wdata[k*BW +: BW];
        end
      end
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (w_mem_be[k]) begin
          r_mem[w_mem_addr][k*BW +: BW] <= w_mem_wdata[k*BW +: BW];
        end
      end
    end
  end

  // First read stage; data holds when no read is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid1 <= 1'b0;
      r_rd_data1  <= '0;
    end else begin
      r_rd_valid1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data1 <= w_rd_word;
      end
    end
  end

  if (READ_LATENCY > 1) begin : g_lat2
    logic          r_rd_valid2;
    logic [DW-1:0] r_rd_data2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_rd_valid2 <= 1'b0;
        r_rd_data2  <= '0;
      end else begin
        r_rd_valid2 <= r_rd_valid1;
        if (r_rd_valid1) begin
          r_rd_data2 <= r_rd_data1;
        end
      end
    end

    assign bus.rd_valid = r_rd_valid2;
    assign bus.rd_data  = r_rd_data2;
  end else begin : g_lat1
    assign bus.rd_valid = r_rd_valid1;
    assign bus.rd_data  = r_rd_data1;
  end

  assign bus.busy = r_busy;

endmodule

// File: doc/ram_simple_dual_port.md
# ram_simple_dual_port

Parametrised simple-dual-port RAM: one write port with byte enables and one independent read port. Read latency, read-during-write behaviour and contents after reset are all configurable. A built-in clear engine sweeps the whole array to a fixed value, either after reset or on request. It is the general-purpose storage block for buffers, lookup tables and register files, replacing the single-port RAM wherever simultaneous read and write or a known initial state is needed.

## Interface
- ADDRESS_WIDTH, 4: address bits. Depth is 2^ADDRESS_WIDTH words.
- DATA_WIDTH, 8: word width. Must be an integer multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per byte lane. Lanes = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1: read latency in cycles. Only 1 or 2 are legal; 2 adds an output register.
- WRITE_FIRST, 0: behaviour on a same-address read and write at the same edge. 0 returns the old word; 1 returns the newly written (merged) word.
- CLEAR_ON_RESET, 1: 1 starts a clear sweep automatically on reset release.
- CLEAR_VALUE, 0: DATA_WIDTH value written to every word during a sweep.
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Clear_i  in  1  single-cycle request to start a clear sweep.
- Busy_o  out  1  high while a sweep is running.
- WriteEnable_i  in  1  write strobe.
- WriteAddress_i  in  ADDRESS_WIDTH  write address.
- WriteByteEnable_i  in  DATA_WIDTH/BYTE_WIDTH  per-lane write enable. Bit k covers bits [k*BYTE_WIDTH +: BYTE_WIDTH].
- WriteData_i  in  DATA_WIDTH  write data.
- ReadEnable_i  in  1  read strobe.
- ReadAddress_i  in  ADDRESS_WIDTH  read address.
- ReadData_o  out  DATA_WIDTH  read data.
- ReadValid_o  out  1  one-cycle qualifier for ReadData_o.

## Operation
- **Reset state**
  - ReadData_o = 0, ReadValid_o = 0, all pipeline stages cleared, sweep counter = 0.
  - FSM state is CLEAR if CLEAR_ON_RESET = 1, otherwise IDLE.
  - Busy_o resets to CLEAR_ON_RESET.
  - The memory array itself is not reset.
- **FSM states**
  - IDLE: normal operation.
  - CLEAR: each edge writes CLEAR_VALUE to mem[counter] and increments the counter.
  - CLEAR -> IDLE on the edge that writes address 2^ADDRESS_WIDTH-1. Busy_o falls on that same edge.
  - IDLE -> CLEAR on an edge with Clear_i = 1. Counter is set to 0 and Busy_o rises.
- **Clear priority**
  - While in CLEAR, Clear_i, WriteEnable_i and ReadEnable_i are ignored and no ReadValid_o is generated.
  - On the edge that accepts Clear_i, any write or read presented at that edge is discarded.
- **Write (IDLE)**
  - Only lanes with WriteByteEnable_i = 1 are updated; other lanes keep their value.
  - A write with all byte enables at 0 changes nothing.
- **Read (IDLE)**
  - ReadEnable_i = 1 fetches mem[ReadAddress_i].
  - When no read is in flight, ReadData_o holds its last value.
- **Read-during-write, same address, same edge**
  - WRITE_FIRST = 0: returns the pre-write word.
  - WRITE_FIRST = 1: returns the byte-merged new word.
  - Different addresses never interact.
- **Reset mid-sweep**: aborts immediately and asynchronously. On release the sweep restarts from address 0 if CLEAR_ON_RESET = 1. Otherwise the FSM stays in IDLE and memory is left partially cleared.

## Timing
- **Sweep duration**: exactly 2^ADDRESS_WIDTH rising edges. Busy_o is high for 2^ADDRESS_WIDTH cycles from the first edge after reset release, or from the edge after Clear_i is accepted.
- **Write**: takes effect at the sampling edge. A read issued at the following edge sees the new data.
- **READ_LATENCY = 1**
  - Read sampled at edge N: ReadData_o and ReadValid_o update at edge N.
  - ReadValid_o is high for one cycle per accepted read.
- **READ_LATENCY = 2**: same as above, but the update happens at edge N+1.
- **Throughput**: one read and one write per cycle, back-to-back, with ReadValid_o continuously high under continuous reads.

## Test plan
- **Clear on reset**: ADDRESS_WIDTH = 4, CLEAR_ON_RESET = 1, CLEAR_VALUE = 8'h5A. Release Reset -> Busy_o high for exactly 16 cycles. Read 0..15 -> every word is 8'h5A with ReadValid_o high.
- **Byte enables**: DATA_WIDTH = 16. Write 16'hABCD to address 3 with WriteByteEnable_i = 2'b11. Then write 16'h1234 to address 3 with 2'b01 -> read of address 3 returns 16'hAB34. A further write with 2'b00 leaves it unchanged.
- **Read-during-write**: mem[5] = 8'h11. At the same edge, write 8'h22 to address 5 and read address 5 -> WRITE_FIRST = 0 returns 8'h11, WRITE_FIRST = 1 returns 8'h22. The next read of address 5 returns 8'h22 in both cases.
- **Latency and throughput**: READ_LATENCY = 2, reads of addresses 0,1,2,3 on consecutive edges -> data appears 2 edges after each request, in order, with ReadValid_o high for 4 consecutive cycles and low before and after.
- **Clear request**: pulse Clear_i with a simultaneous write of 8'hFF to address 7 -> write dropped, Busy_o high for 16 cycles, reads during Busy_o give ReadValid_o = 0. Afterwards address 7 reads CLEAR_VALUE.
- **Reset mid-sweep**: assert Reset when the counter is 7 -> ReadData_o = 0, ReadValid_o = 0 and Busy_o = 1 immediately, without waiting for a clock edge. On release, Busy_o stays high for a full 16 cycles and all words read CLEAR_VALUE.
